// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcodes, ALUOp encodings and the packed control word
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // All-zero value of this word is a bubble.
    typedef struct packed {
        logic       regdst;
        logic       jump;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detection for the ID/EX stage
module load_use_detect #(
    parameter int RW = 5
) (
    input  logic          ex_valid_i,
    input  logic          ex_memread_i,
    input  logic [RW-1:0] ex_wreg_i,
    input  logic          id_valid_i,
    input  logic [RW-1:0] id_rs_i,
    input  logic [RW-1:0] id_rt_i,
    output logic          stall_o
);

    // A load into $0 never produces a value worth waiting for.
    assign stall_o = ex_valid_i && ex_memread_i && (ex_wreg_i != '0) && id_valid_i &&
                     ((ex_wreg_i == id_rs_i) || (ex_wreg_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with flush/load-use bubbles and hold
// Optional feature: ID_EX_HAZARD_EN enables load-use detection and stall_out.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic          Regdst,
    input  logic          Jump,
    input  logic          Branch,
    input  logic          Memread,
    input  logic          MemtoReg,
    input  logic          Memwrite,
    input  logic          ALUSrc,
    input  logic          Regwrite,
    input  logic [1:0]    ALUOp,
    input  logic [DW-1:0] id_pc4,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [5:0]    id_funct,
    input  logic          flush_in,
    input  logic          hold_in,
    output logic          ex_valid,
    output logic          ex_Regdst,
    output logic          ex_Jump,
    output logic          ex_Branch,
    output logic          ex_Memread,
    output logic          ex_MemtoReg,
    output logic          ex_Memwrite,
    output logic          ex_ALUSrc,
    output logic          ex_Regwrite,
    output logic [1:0]    ex_ALUOp,
    output logic [DW-1:0] ex_pc4,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_rd,
    output logic [5:0]    ex_funct,
    output logic [RW-1:0] ex_wreg,
    output logic          stall_out,
    output logic [15:0]   bubble_count
);

    ctrl_t         id_ctrl, ctrl_d, ctrl_q;
    logic          valid_d, valid_q;
    logic [DW-1:0] pc4_d, pc4_q, rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
    logic [RW-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q, wreg_d, wreg_q;
    logic [5:0]    funct_d, funct_q;
    logic [15:0]   bub_d, bub_q;
    logic [RW-1:0] id_wreg;
    logic          stall;

`ifdef ID_EX_HAZARD_EN
    load_use_detect #(.RW(RW)) u_load_use_detect (
        .ex_valid_i   (valid_q),
        .ex_memread_i (ctrl_q.memread),
        .ex_wreg_i    (wreg_q),
        .id_valid_i   (id_valid),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .stall_o      (stall)
    );
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        id_wreg          = Regdst ? id_rd : id_rt;
        id_ctrl.regdst   = Regdst;
        id_ctrl.jump     = Jump;
        id_ctrl.branch   = Branch;
        id_ctrl.memread  = Memread;
        id_ctrl.memtoreg = MemtoReg;
        id_ctrl.memwrite = Memwrite;
        id_ctrl.alusrc   = ALUSrc;
        id_ctrl.regwrite = Regwrite && (id_wreg != '0);
        id_ctrl.aluop    = ALUOp;
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        pc4_d   = pc4_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        wreg_d  = wreg_q;
        funct_d = funct_q;
        bub_d   = bub_q;
        // Flush beats hold; a load-use bubble only happens when not frozen.
        if (flush_in || (!hold_in && stall)) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
            pc4_d   = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            wreg_d  = '0;
            funct_d = '0;
            bub_d   = sat_inc16(bub_q);
        end else if (!hold_in) begin
            ctrl_d  = id_valid ? id_ctrl : '0;
            valid_d = id_valid;
            pc4_d   = id_pc4;
            rd1_d   = id_rd1;
            rd2_d   = id_rd2;
            imm_d   = id_imm;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            wreg_d  = id_wreg;
            funct_d = id_funct;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            wreg_q  <= '0;
            funct_q <= '0;
            bub_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            pc4_q   <= pc4_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            wreg_q  <= wreg_d;
            funct_q <= funct_d;
            bub_q   <= bub_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_Regdst    = ctrl_q.regdst;
    assign ex_Jump      = ctrl_q.jump;
    assign ex_Branch    = ctrl_q.branch;
    assign ex_Memread   = ctrl_q.memread;
    assign ex_MemtoReg  = ctrl_q.memtoreg;
    assign ex_Memwrite  = ctrl_q.memwrite;
    assign ex_ALUSrc    = ctrl_q.alusrc;
    assign ex_Regwrite  = ctrl_q.regwrite;
    assign ex_ALUOp     = ctrl_q.aluop;
    assign ex_pc4       = pc4_q;
    assign ex_rd1       = rd1_q;
    assign ex_rd2       = rd2_q;
    assign ex_imm       = imm_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_rd        = rd_q;
    assign ex_funct     = funct_q;
    assign ex_wreg      = wreg_q;
    assign stall_out    = stall;
    assign bubble_count = bub_q;

endmodule
